// File: rtl/wb_block_reader.sv
// Pipelined Wishbone block reader: fetches count_i consecutive 32-bit words from base_i,
// one transaction outstanding, and streams them out over a valid/ready handshake.
module wb_block_reader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  logic [7:0]  count_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [29:0] r_addr;
  logic [7:0]  r_cnt;
  logic [15:0] r_tmo;
  logic        r_busy, r_done, r_err, r_valid;
  logic [31:0] r_data;

  // Slave responses count in WAIT, and in REQ only once the strobe has been taken.
  logic w_resp_ok, w_abort, w_ack, w_tmo;
  assign w_resp_ok = (r_state == S_WAIT) || ((r_state == S_REQ) && !wb_stall_i);
  assign w_abort   = w_resp_ok && (wb_err_i || wb_rty_i);
  assign w_ack     = w_resp_ok && wb_ack_i && !wb_err_i && !wb_rty_i;
  assign w_tmo     = (r_tmo == TMO_LAST);

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, base_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // busy stays up through the done cycle so a start there is still ignored
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !r_busy) begin
            r_addr  <= base_i[31:2];
            r_cnt   <= count_i;
            r_tmo   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (w_abort || (!w_ack && w_tmo)) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_data  <= wb_dat_i;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end else begin
            r_tmo <= r_tmo + 16'd1;
            if (r_state == S_REQ && !wb_stall_i) r_state <= S_WAIT;
          end
        end
        S_OUT: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_addr  <= r_addr + 30'd1;
            r_cnt   <= r_cnt - 8'd1;
            // count 0 wraps through 255 down to 1, giving 256 words
            if (r_cnt == 8'd1) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tmo   <= '0;
              r_state <= S_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign error_o  = r_err;
  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign wb_cyc_o = (r_state == S_REQ) || (r_state == S_WAIT);
  assign wb_stb_o = (r_state == S_REQ);
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_adr_o = {r_addr, 2'b00};
  assign wb_dat_o = '0;

endmodule

// File: tb/tb_wb_block_reader.sv
// Directed bench for wb_block_reader: Wishbone slave model with stall/err/rty/no-ack knobs,
// address and data scoreboards filled at block start and drained as the DUT produces them.
module tb_wb_block_reader;

  logic        clk = 1'b0;
  logic        rst_n_i, start_i, ready_i;
  logic [31:0] base_i;
  logic [7:0]  count_i;
  logic        busy_o, done_o, error_o, valid_o;
  logic [31:0] data_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;

  always #5 clk = ~clk;

  wb_block_reader #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .base_i(base_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  int nvec = 0, nerr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  int stall_word = -1, err_word = -1, rty_word = -1;
  bit noack = 0, ack0 = 0, force_ack = 0;
  bit pend = 0;
  int idx = 0, stall_cnt = 0;
  logic [31:0] lat_adr = '0;

  function automatic logic [31:0] model(input logic [31:0] a);
    return a ^ 32'hC3A5_0F96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task respond();
    if (idx == err_word) begin
      wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = model(lat_adr);
    end else if (idx == rty_word) begin
      wb_rty_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = model(lat_adr);
    end else if (!noack) begin
      wb_ack_i = 1'b1; wb_dat_i = model(lat_adr);
    end
    idx++;
  endtask

  // Slave: decides stall/ack on the falling edge so the DUT sees it at the next rising edge.
  always @(negedge clk) begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
    if (!busy_o) begin
      pend = 0; idx = 0; stall_cnt = 0;
      wb_ack_i = force_ack; wb_dat_i = 32'h1234_5678;
    end else begin
      if (pend) begin respond(); pend = 0; end
      if (wb_stb_o) begin
        if (idx == stall_word && stall_cnt < 5) begin
          wb_stall_i = 1'b1;
          stall_cnt++;
        end else begin
          chk("addr_expected", 32'(addr_q.size() != 0), 32'd1);
          if (addr_q.size() != 0) chk("wb_adr", wb_adr_o, addr_q.pop_front());
          lat_adr = wb_adr_o;
          if (ack0) respond(); else pend = 1;
        end
      end
    end
  end

  // Stream monitor: compare each transferred word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n_i === 1'b1 && valid_o === 1'b1) begin
      chk("cyc_in_out", 32'(wb_cyc_o), 32'd0);
      if (ready_i) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("data_o", data_o, exp_q.pop_front());
      end
    end
  end

  task automatic start_block(input logic [31:0] base, input int cnt, input int naddr, input int ndata);
    logic [31:0] a;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < naddr; i++) addr_q.push_back(a + 32'(4 * i));
    for (int i = 0; i < ndata; i++) exp_q.push_back(model(a + 32'(4 * i)));
    start_i = 1'b1; base_i = base; count_i = 8'(cnt);
    @(negedge clk);
    start_i = 1'b0; base_i = '0; count_i = '0;
  endtask

  task automatic wait_done(input logic exp_err, input int exp_cyc, input int exp_stb, input int exp_t);
    int cyc = 0, stb = 0, t = 0;
    while (!done_o && t < 3000) begin
      if (wb_cyc_o) cyc++;
      if (wb_stb_o) stb++;
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("error_at_done", 32'(error_o), 32'(exp_err));
    chk("busy_at_done", 32'(busy_o), 32'd1);
    chk("cyc_at_done", 32'(wb_cyc_o), 32'd0);
    if (exp_cyc >= 0) chk("cyc_cycles", 32'(cyc), 32'(exp_cyc));
    if (exp_stb >= 0) chk("stb_cycles", 32'(stb), 32'(exp_stb));
    if (exp_t >= 0) chk("block_latency", 32'(t), 32'(exp_t));
    chk("words_left", 32'(exp_q.size()), 32'd0);
    chk("addrs_left", 32'(addr_q.size()), 32'd0);
    @(negedge clk);
    chk("busy_after_done", 32'(busy_o), 32'd0);
    chk("done_one_cycle", 32'(done_o), 32'd0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
  endtask

  initial begin
    int t;
    rst_n_i = 1'b0; start_i = 1'b0; base_i = '0; count_i = '0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    chk("we_const", 32'(wb_we_o), 32'd0);
    chk("sel_const", 32'(wb_sel_o), 32'hF);
    chk("dat_o_const", wb_dat_o, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk);

    // four words, ack one cycle after the strobe
    start_block(32'h100, 4, 4, 4);
    wait_done(1'b0, 8, 4, -1);

    // same-cycle ack: REQ, OUT per word; low address bits ignored
    ack0 = 1;
    start_block(32'h2003, 2, 2, 2);
    wait_done(1'b0, 2, 2, 4);
    ack0 = 0;

    // five stall cycles on word 2 keep the strobe up six cycles
    stall_word = 1;
    start_block(32'h300, 3, 3, 3);
    wait_done(1'b0, 11, 8, -1);
    stall_word = -1;

    // err together with ack on word 3 of 5
    err_word = 2;
    start_block(32'h400, 5, 3, 2);
    wait_done(1'b1, 6, 3, -1);
    err_word = -1;

    // rty together with ack on word 2 of 3
    rty_word = 1;
    start_block(32'h500, 3, 2, 1);
    wait_done(1'b1, 4, 2, -1);
    rty_word = -1;

    // slave never answers: abort after 16 cycles on the bus
    noack = 1;
    start_block(32'h600, 2, 1, 0);
    wait_done(1'b1, 16, 1, -1);
    noack = 0;

    // back-pressure: word held, no bus activity, start while busy ignored
    ready_i = 1'b0;
    start_block(32'h700, 1, 1, 1);
    t = 0;
    while (!valid_o && t < 50) begin @(negedge clk); t++; end
    chk("valid_seen", 32'(valid_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_data", data_o, model(32'h700));
      chk("hold_valid", 32'(valid_o), 32'd1);
      chk("hold_no_cyc", 32'(wb_cyc_o), 32'd0);
      if (i == 3) begin start_i = 1'b1; base_i = 32'h9000; count_i = 8'd3; end
      if (i == 4) begin start_i = 1'b0; base_i = '0; count_i = '0; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    wait_done(1'b0, -1, -1, -1);

    // count 0 = 256 words, address wraps past the top of memory
    start_block(32'hFFFF_FFF8, 256, 256, 256);
    wait_done(1'b0, 512, 256, -1);

    // reset while waiting for ack, then a late ack must be ignored
    noack = 1;
    start_block(32'h800, 2, 1, 0);
    t = 0;
    while (!(wb_cyc_o && !wb_stb_o) && t < 20) begin @(negedge clk); t++; end
    chk("reached_wait", 32'(wb_cyc_o && !wb_stb_o), 32'd1);
    rst_n_i = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    force_ack = 1;
    rst_n_i = 1'b1;
    noack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ack_valid", 32'(valid_o), 32'd0);
      chk("late_ack_busy", 32'(busy_o), 32'd0);
      chk("late_ack_cyc", 32'(wb_cyc_o), 32'd0);
    end
    force_ack = 0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);

    // normal operation after reset
    start_block(32'h900, 2, 2, 2);
    wait_done(1'b0, 4, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
